pipe_stage_skid: RTL and testbench



---
 rtl/pipe_stage_skid.sv | 193 +++++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Elastic pipeline register placed between two CPU pipeline stages. It
// carries a payload, control bits and a destination register index through
// a valid/ready handshake and holds up to two entries: the main entry, which
// drives the outputs, and a skid entry, which catches the one extra entry
// that can arrive in the cycle the downstream stage starts to stall. A
// synchronous flush throws away everything held and turns the stage into a
// bubble. A saturating counter records how many cycles the stage spent
// holding a valid entry that downstream refused, for performance debug.
//
// Parameters
//   DATA_W  payload width
//   CTRL_W  control-bit width (reads as zero on bubbles)
//   IDX_W   destination register index width
//   CNT_W   stall counter width
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous, active-high; clears all state
//   in_valid   upstream entry valid
//   in_ready   stage can accept this cycle (registered-state decode only)
//   in_data    upstream payload
//   in_ctrl    upstream control bits
//   in_idx     upstream destination index
//   flush      synchronous kill of all held entries
//   out_valid  output entry valid
//   out_ready  downstream accepts output
//   out_data   payload of head entry (holds last value while empty)
//   out_ctrl   control of head entry, zero when out_valid is low
//   out_idx    destination index of head entry (holds while empty)
//   clr_cnt    synchronous clear of stall_cnt
//   stall_cnt  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int DATA_W = 97,
  parameter int CTRL_W = 6,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [IDX_W-1:0]  out_idx,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [IDX_W-1:0]  main_idx;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [IDX_W-1:0]  skid_idx;

  logic accept;
  logic take;
  logic load_main_in;
  logic load_skid;
  logic move_skid;

  // Handshake flags come only from the registered state, so neither ready
  // nor valid has a combinational path from the opposite side of the stage.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  // The main entry is always the head of the queue; control bits are masked
  // so a bubble can never leak stale control into the next stage.
  assign out_data = main_data;
  assign out_idx  = main_idx;
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

  // Next-state and load decode. New input only goes to main when main is
  // free or is being handed off this cycle, otherwise it lands in skid; the
  // skid entry is only ever promoted into main, which keeps strict FIFO
  // order. Flush overrides everything and suppresses all loads so the
  // same-cycle input is dropped.
  always_comb begin
    next_state   = state;
    load_main_in = 1'b0;
    load_skid    = 1'b0;
    move_skid    = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          next_state   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && take) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end else if (take) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          next_state = ONE;
          move_skid  = 1'b1;
        end
      end
      default: begin
        next_state = EMPTY;
      end
    endcase
    if (flush) begin
      next_state   = EMPTY;
      load_main_in = 1'b0;
      load_skid    = 1'b0;
      move_skid    = 1'b0;
    end
  end

  // Occupancy state register; reset discards entries immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Main entry storage. It is left untouched while empty so the payload
  // and index keep showing the last delivered entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data <= '0;
      main_ctrl <= '0;
      main_idx  <= '0;
    end else if (load_main_in) begin
      main_data <= in_data;
      main_ctrl <= in_ctrl;
      main_idx  <= in_idx;
    end else if (move_skid) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
      main_idx  <= skid_idx;
    end
  end

  // Skid entry storage, written only by the single entry that arrives in the
  // cycle downstream begins to stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_data <= '0;
      skid_ctrl <= '0;
      skid_idx  <= '0;
    end else if (load_skid) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
      skid_idx  <= in_idx;
    end
  end

  // Stall counter: counts cycles with a valid head refused downstream,
  // sticks at all-ones, and a clear request beats a same-cycle increment.
  // Flush deliberately does not touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed and randomised checks for pipe_stage_skid: reset values,
// streaming, backpressure into the skid entry, flush, stall counter
// saturation and clear, asynchronous reset mid-operation, and a random
// valid/ready run compared against a FIFO scoreboard.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int DATA_W = 97;
  localparam int CTRL_W = 6;
  localparam int IDX_W  = 5;
  localparam int CNT_W  = 4;
  localparam int ENT_W  = DATA_W + CTRL_W + IDX_W;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic [IDX_W-1:0]  in_idx;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [IDX_W-1:0]  out_idx;
  logic              clr_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int checks;
  int errors;

  logic [ENT_W-1:0] sb_q[$];

  pipe_stage_skid #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_idx   (in_idx),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .out_idx  (out_idx),
    .clr_cnt  (clr_cnt),
    .stall_cnt(stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one upstream entry (or none when valid is 0).
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                               input logic [CTRL_W-1:0] c,
                               input logic [IDX_W-1:0] i, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    in_idx    = i;
    out_ready = rdy;
  endtask

  initial begin
    logic             r0;
    logic             acc;
    logic             tk;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] ent;
    int               guard;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    flush  = 1'b0;
    clr_cnt = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b0);

    // Reset values
    #2;
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_out_data", 128'(out_data), 128'd0);
    checkOutput("rst_out_ctrl", 128'(out_ctrl), 128'd0);
    checkOutput("rst_out_idx", 128'(out_idx), 128'd0);
    checkOutput("rst_stall_cnt", 128'(stall_cnt), 128'd0);
    step();
    reset = 1'b0;

    // Streaming A, B, C with downstream always ready
    applyStimulus(1'b1, 97'h1, 6'h01, 5'd1, 1'b1);
    step();
    checkOutput("str_valid_a", 128'(out_valid), 128'd1);
    checkOutput("str_data_a", 128'(out_data), 128'h1);
    checkOutput("str_ready_a", 128'(in_ready), 128'd1);
    applyStimulus(1'b1, 97'h2, 6'h02, 5'd2, 1'b1);
    step();
    checkOutput("str_data_b", 128'(out_data), 128'h2);
    checkOutput("str_idx_b", 128'(out_idx), 128'd2);
    applyStimulus(1'b1, 97'h3, 6'h03, 5'd3, 1'b1);
    step();
    checkOutput("str_data_c", 128'(out_data), 128'h3);
    checkOutput("str_ctrl_c", 128'(out_ctrl), 128'h3);
    checkOutput("str_ready_c", 128'(in_ready), 128'd1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    step();
    checkOutput("str_empty_valid", 128'(out_valid), 128'd0);
    checkOutput("str_empty_hold", 128'(out_data), 128'h3);
    checkOutput("str_empty_ctrl", 128'(out_ctrl), 128'd0);
    checkOutput("str_stall_cnt", 128'(stall_cnt), 128'd0);

    // Backpressure: A held in main, B caught in skid
    applyStimulus(1'b1, 97'hA, 6'h02, 5'd3, 1'b0);
    step();
    checkOutput("bp_data_a", 128'(out_data), 128'hA);
    checkOutput("bp_ready_one", 128'(in_ready), 128'd1);
    applyStimulus(1'b1, 97'hB, 6'h04, 5'd4, 1'b0);
    step();
    checkOutput("bp_ready_full", 128'(in_ready), 128'd0);
    checkOutput("bp_hold_a", 128'(out_data), 128'hA);
    checkOutput("bp_cnt1", 128'(stall_cnt), 128'd1);
    applyStimulus(1'b1, 97'hC, 6'h05, 5'd5, 1'b0);
    step();
    checkOutput("bp_cnt2", 128'(stall_cnt), 128'd2);
    checkOutput("bp_still_a", 128'(out_data), 128'hA);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    step();
    checkOutput("bp_data_b", 128'(out_data), 128'hB);
    checkOutput("bp_idx_b", 128'(out_idx), 128'd4);
    checkOutput("bp_ready_back", 128'(in_ready), 128'd1);
    checkOutput("bp_cnt_hold", 128'(stall_cnt), 128'd2);
    step();
    checkOutput("bp_drained", 128'(out_valid), 128'd0);

    // Flush while FULL with a same-cycle incoming entry
    applyStimulus(1'b1, 97'hD, 6'h01, 5'd6, 1'b0);
    step();
    applyStimulus(1'b1, 97'hE, 6'h01, 5'd7, 1'b0);
    step();
    checkOutput("fl_full", 128'(in_ready), 128'd0);
    checkOutput("fl_cnt_pre", 128'(stall_cnt), 128'd3);
    applyStimulus(1'b1, 97'h77, 6'h3F, 5'd9, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("fl_valid", 128'(out_valid), 128'd0);
    checkOutput("fl_ctrl", 128'(out_ctrl), 128'd0);
    checkOutput("fl_ready", 128'(in_ready), 128'd1);
    checkOutput("fl_cnt_kept", 128'(stall_cnt), 128'd4);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    step();
    checkOutput("fl_no_ghost", 128'(out_valid), 128'd0);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    checkOutput("clr_idle", 128'(stall_cnt), 128'd0);

    // Stall counter saturation, then clear beating a same-cycle stall
    applyStimulus(1'b1, 97'h55, 6'h01, 5'd1, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    for (int k = 0; k < (1 << CNT_W) + 5; k++) step();
    checkOutput("sat_cnt", 128'(stall_cnt), 128'hF);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    checkOutput("clr_wins", 128'(stall_cnt), 128'd0);
    step();
    checkOutput("cnt_restart", 128'(stall_cnt), 128'd1);

    // Asynchronous reset between edges while FULL
    applyStimulus(1'b1, 97'h66, 6'h01, 5'd2, 1'b0);
    step();
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    checkOutput("ar_full", 128'(in_ready), 128'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_valid", 128'(out_valid), 128'd0);
    checkOutput("ar_ready", 128'(in_ready), 128'd1);
    checkOutput("ar_data", 128'(out_data), 128'd0);
    checkOutput("ar_cnt", 128'(stall_cnt), 128'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 97'h99, 6'h02, 5'd8, 1'b1);
    step();
    checkOutput("ar_resume_valid", 128'(out_valid), 128'd1);
    checkOutput("ar_resume_data", 128'(out_data), 128'h99);
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    step();
    checkOutput("ar_resume_empty", 128'(out_valid), 128'd0);

    // Random valid/ready traffic against a FIFO scoreboard
    sb_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r0 = in_ready;
      ent = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1'($urandom_range(0, 1)), ent[ENT_W-1:IDX_W+CTRL_W],
                    ent[IDX_W+CTRL_W-1:IDX_W], ent[IDX_W-1:0],
                    1'($urandom_range(0, 1)));
      #1;
      checkOutput("rnd_ready_indep", 128'(in_ready), 128'(r0));
      acc = in_valid & in_ready;
      tk  = out_valid & out_ready;
      if (tk) begin
        if (sb_q.size() == 0) begin
          checkOutput("rnd_unexpected", 128'(out_data), 128'd0 - 128'd1);
        end else begin
          head = sb_q.pop_front();
          checkOutput("rnd_entry", 128'({out_data, out_ctrl, out_idx}),
                      128'(head));
        end
      end
      if (acc) sb_q.push_back({in_data, in_ctrl, in_idx});
      step();
    end

    // Drain what is left, bounded
    applyStimulus(1'b0, '0, '0, '0, 1'b1);
    guard = 0;
    while (out_valid && guard < 8) begin
      if (sb_q.size() == 0) begin
        checkOutput("drain_extra", 128'(out_valid), 128'd0);
      end else begin
        head = sb_q.pop_front();
        checkOutput("drain_entry", 128'({out_data, out_ctrl, out_idx}),
                    128'(head));
      end
      step();
      guard++;
    end
    checkOutput("drain_done", 128'(out_valid), 128'd0);
    checkOutput("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
